factorial_sched: RTL
====================

FACTORIAL_SCHED -- requirements
Module: factorial_sched

Interface
REQ-001 SHALL have parameter SIZE, default 8, operand/result width.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter MAX_N, default 5, largest n whose factorial fits in SIZE bits.
REQ-004 SHALL have parameter TIMEOUT, default 255, max engine cycles before abort.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 req  input  NUM_REQ  per-requester request level.
REQ-008 req_n  input  NUM_REQ*SIZE  packed operands; slice i = requester i.
REQ-009 ack  output  NUM_REQ  one-hot, one-cycle response pulse.
REQ-010 rsp_result  output  SIZE  result, valid when any ack bit is set.
REQ-011 rsp_err  output  2  00 ok, 01 range, 10 timeout; valid with ack.
REQ-012 eng_go  output  1  one-cycle start pulse to the factorial engine.
REQ-013 eng_n  output  SIZE  engine operand.
REQ-014 eng_done  input  1  engine completion.
REQ-015 eng_result  input  SIZE  engine result, valid with eng_done.
REQ-016 state  output  2  current FSM state; busy  output  1  high when state != IDLE.

Function
REQ-017 FSM states SHALL be IDLE=0, LAUNCH=1, WAIT=2, RESP=3.
- IDLE -> LAUNCH on a granted request with n <= MAX_N.
- IDLE -> RESP on a granted request with n > MAX_N.
- LAUNCH -> WAIT always.
- WAIT -> RESP on eng_done or on timeout.
- RESP -> IDLE always.
REQ-018 In IDLE with any req set, the block SHALL grant round-robin, starting at the index after the last granted; after reset the search starts at index 0.
REQ-019 The granted index and its operand SHALL be latched in the grant cycle; later changes on req_n SHALL be ignored.
REQ-020 eng_go SHALL be high only in LAUNCH, for exactly one cycle; eng_n SHALL hold the latched operand from LAUNCH until RESP.
REQ-021 In WAIT, the first cycle with eng_done=1 SHALL latch eng_result; eng_done outside WAIT SHALL be ignored.
REQ-022 The timeout counter SHALL clear in LAUNCH and increment each WAIT cycle; if it reaches TIMEOUT without eng_done, the block SHALL go to RESP with rsp_err=10 and rsp_result=0.
REQ-023 On the range error path, rsp_err SHALL be 01, rsp_result 0, and eng_go SHALL never assert.
REQ-024 In RESP, ack[granted] SHALL be high for exactly one cycle; all other ack bits SHALL be 0.
REQ-025 rsp_result and rsp_err SHALL be 0 whenever ack is all-zero.
REQ-026 Requesters SHALL hold req and their operand until ack, then drop req in the next cycle; the scheduler SHALL NOT re-grant the same requester in the cycle after its ack (IDLE re-arbitrates from the next index).
REQ-027 If req[granted] drops before ack, the transaction SHALL still complete and ack SHALL still pulse.
REQ-028 Latency (ok path): grant cycle t, eng_go at t+1, eng_done at cycle d >= t+2, ack at d+1.
REQ-029 Latency (range path): grant cycle t, ack at t+1.
REQ-030 n=0 and n=1 SHALL be forwarded to the engine like any in-range n (no shortcut).

Reset
REQ-031 rst SHALL force: state=IDLE, round-robin pointer=0, ack=0, rsp_result=0, rsp_err=0, eng_go=0, eng_n=0, timeout counter=0, busy=0.
REQ-032 rst asserted mid-transaction SHALL abandon it with no ack; a later eng_done SHALL be ignored.

Structure
REQ-033 Package factorial_pkg SHALL hold the state encoding, the rsp_err codes, and default SIZE/MAX_N.
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req and pointer; outputs one-hot grant and index); the rest is one FSM module.

Verification
REQ-035 Single requester 2, n=5; engine done 6 cycles after eng_go -> eng_go once, eng_n=5, ack[2] with rsp_result=120, rsp_err=00.
REQ-036 req=4'b1111 held, all n=3 -> acks in order 0,1,2,3,0; each rsp_result=6.
REQ-037 Requester 1, n=7 -> ack[1] the cycle after grant, rsp_err=01, rsp_result=0, eng_go never high.
REQ-038 Engine never asserts eng_done -> ack TIMEOUT+2 cycles after eng_go, rsp_err=10, rsp_result=0.
REQ-039 rst pulse during WAIT, then eng_done -> no ack, state=IDLE; next request is granted from index 0.
REQ-040 eng_done pulse in IDLE, and req_n changed during WAIT -> the stray eng_done is ignored and rsp_result reflects the latched operand.

Source files
------------

// File: rtl/factorial_pkg.sv
// factorial_pkg: shared definitions for the factorial request scheduler.
//   state_t      - scheduler FSM encoding (also driven out on the state port)
//   ERR_*        - response error codes carried on rsp_err
//   DEF_SIZE     - default operand/result width
//   DEF_MAX_N    - default largest operand whose factorial fits DEF_SIZE bits
//   idx_width()  - width of a requester index for a given requester count
package factorial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_RANGE   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int DEF_SIZE  = 8;
  localparam int DEF_MAX_N = 5;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin selector.
//   req   [NUM_REQ-1:0] - request vector
//   ptr   [IDX_W-1:0]   - index where the search starts (highest priority)
//   grant [NUM_REQ-1:0] - one-hot grant, all-zero when no request
//   idx   [IDX_W-1:0]   - index of the granted requester (0 when none)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Walk the requesters starting at ptr, wrapping modulo NUM_REQ; the first
  // active one wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/factorial_sched.sv
// factorial_sched: arbitrates NUM_REQ requesters onto one external factorial
// engine and returns the result to the granted requester.
//   clk, rst            - clock, synchronous active-high reset
//   req, req_n          - per-requester request level and packed operands
//   ack                 - one-hot, one-cycle response pulse
//   rsp_result, rsp_err - response payload, zero whenever ack is zero
//   eng_go, eng_n       - engine start pulse and operand
//   eng_done, eng_result- engine completion and result
//   state, busy         - FSM state (debug) and non-idle indicator
//
// Handshake: a requester raises req with a stable operand and holds both
// until its ack pulse; the response payload is valid only in the ack cycle.
// Toward the engine, eng_go is a single-cycle start; the first eng_done seen
// while waiting completes the job and any eng_done at other times is ignored.
module factorial_sched
  import factorial_pkg::*;
#(
  parameter int SIZE    = DEF_SIZE,
  parameter int NUM_REQ = 4,
  parameter int MAX_N   = DEF_MAX_N,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*SIZE-1:0] req_n,
  output logic [NUM_REQ-1:0]      ack,
  output logic [SIZE-1:0]         rsp_result,
  output logic [1:0]              rsp_err,
  output logic                    eng_go,
  output logic [SIZE-1:0]         eng_n,
  input  logic                    eng_done,
  input  logic [SIZE-1:0]         eng_result,
  output logic [1:0]              state,
  output logic                    busy
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             cur, nxt;
  logic [IDX_W-1:0]   ptr_q, idx_q, g_idx;
  logic [NUM_REQ-1:0] g_onehot, req_eff, last_mask;
  logic [SIZE-1:0]    n_sel, n_q, res_q;
  logic [1:0]         err_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               after_ack_q;
  logic               grant_valid, n_range, timed_out;

  // The requester just acknowledged may still show req in the following
  // cycle; hide it so it cannot be re-granted back to back.
  assign last_mask = NUM_REQ'(1) << idx_q;
  assign req_eff   = req & ~(after_ack_q ? last_mask : '0);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (req_eff),
    .ptr   (ptr_q),
    .grant (g_onehot),
    .idx   (g_idx)
  );

  assign grant_valid = |g_onehot;
  assign n_sel       = req_n[int'(g_idx)*SIZE +: SIZE];
  assign n_range     = n_sel > SIZE'(MAX_N);
  assign timed_out   = cnt_q == CNT_W'(TIMEOUT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) cur <= ST_IDLE;
    else     cur <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = cur;
    unique case (cur)
      ST_IDLE:   if (grant_valid) nxt = n_range ? ST_RESP : ST_LAUNCH;
      ST_LAUNCH: nxt = ST_WAIT;
      ST_WAIT:   if (eng_done || timed_out) nxt = ST_RESP;
      ST_RESP:   nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  // Datapath: grant latch, round-robin pointer, timeout counter, response.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      idx_q       <= '0;
      n_q         <= '0;
      res_q       <= '0;
      err_q       <= ERR_OK;
      cnt_q       <= '0;
      after_ack_q <= 1'b0;
    end else begin
      after_ack_q <= (cur == ST_RESP);
      unique case (cur)
        ST_IDLE: begin
          if (grant_valid) begin
            idx_q <= g_idx;
            n_q   <= n_sel;
            ptr_q <= (g_idx == IDX_W'(NUM_REQ - 1)) ? '0 : g_idx + IDX_W'(1);
            res_q <= '0;
            err_q <= n_range ? ERR_RANGE : ERR_OK;
          end
        end
        ST_LAUNCH: cnt_q <= '0;
        ST_WAIT: begin
          if (eng_done) begin
            res_q <= eng_result;
            err_q <= ERR_OK;
          end else if (timed_out) begin
            res_q <= '0;
            err_q <= ERR_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ack        = (cur == ST_RESP) ? last_mask : '0;
  assign rsp_result = (cur == ST_RESP) ? res_q : '0;
  assign rsp_err    = (cur == ST_RESP) ? err_q : ERR_OK;
  assign eng_go     = (cur == ST_LAUNCH);
  assign eng_n      = n_q;
  assign state      = cur;
  assign busy       = (cur != ST_IDLE);

endmodule
